baser_257b_multilane_checker: RTL and testbench
===============================================

Name: baser_257b_multilane_checker

Overview:
- Receive-side checker for NUM_LANES independent 257b transcoded streams, taken before the descrambler stage of the BASE-R verification path.
- Per lane, it decodes each 257b block into four 66b blocks and validates the header and block types.
- Per lane, it keeps saturating statistics counters and runs a block-lock / high-error-rate state machine.
- It is the multi-lane, lock-aware successor of the single-channel 257b checker.

Parameters:
- NUM_LANES, 4: number of independent lanes.
- TC_WIDTH, 257: transcoded block width. Fixed; other values are unsupported.
- FRAME_WIDTH, 66: recovered block width as {payload[63:0], hdr[1:0]}.
- CNT_WIDTH, 32: width of each statistics counter.
- LOCK_GOOD, 64: consecutive valid blocks required to declare lock.
- ERR_WINDOW, 64: length, in blocks, of the error-monitoring window while locked.
- ERR_THRESH, 16: invalid blocks within one window that cause loss of lock.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous assert, active low
- i_valid  in  NUM_LANES  per-lane block strobe
- i_rx_xcoded  in  NUM_LANES*TC_WIDTH  lane k occupies bits [k*257 +: 257]
- i_clear  in  1  synchronous clear of counters and the sticky hi_ber flag, all lanes
- o_valid  out  NUM_LANES  registered copy of i_valid
- o_rx_coded  out  NUM_LANES*4*FRAME_WIDTH  lane k, block j at [(k*4+j)*66 +: 66]
- o_inv_flag  out  NUM_LANES  current block invalid, qualified by o_valid
- o_block_lock  out  NUM_LANES  lane is in LOCKED
- o_hi_ber  out  NUM_LANES  sticky: lane lost lock from LOCKED
- o_block_count  out  NUM_LANES*CNT_WIDTH  valid-strobed blocks received
- o_data_count  out  NUM_LANES*CNT_WIDTH  all-data blocks (bit0 = 1)
- o_ctrl_count  out  NUM_LANES*CNT_WIDTH  valid blocks containing at least one control block
- o_inv_count  out  NUM_LANES*CNT_WIDTH  invalid blocks

Behaviour:
Reset (i_rst_n = 0, asynchronous):
- All outputs are 0, all FSMs are UNLOCKED, all internal counters are 0.
- Reset mid-stream discards the in-flight block.

Decode (per lane, only when i_valid[k] = 1):
- Bit0 = 1: all-data block.
  - Block j = {x[64*j+64 : 64*j+1], 2'b01}.
- Bit0 = 0: control block present.
  - x[4:1] are per-block flags, bit1 for block 0; 1 = data, 0 = control.
  - x[256:5] carries the blocks in order.
  - The first control block carries only a 4-bit type nibble plus 56 payload bits (60 bits total).
  - Every other block carries 64 bits.
  - Recovered headers are 2'b01 for data and 2'b10 for control.
- The first control type is restored from its nibble with this map:
  - 0x1E, 0x2D, 0x33, 0x4B, 0x55, 0x66, 0x78, 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF, keyed on their low nibble.
  - Low nibble 0x0 is invalid.
- A block is invalid if any of the following holds:
  - bit0 = 0 and flags = 4'b1111;
  - the first control nibble is 0x0;
  - any later control block's type byte is not in the set above.
- On an invalid block, all four output blocks are forced to the error block: hdr 2'b10, type 0x1E, eight 7'h1E characters.

Latency and counters:
- Outputs register 1 cycle after input.
- When i_valid[k] = 0, o_valid[k] = 0 and o_rx_coded, o_inv_flag and all counters hold.
- Counters saturate at all-ones and do not wrap.
- o_block_count = o_data_count + o_ctrl_count + o_inv_count until saturation.
- i_clear has priority: the counter loads 0 plus the current cycle's increment, so a valid block in the clear cycle yields a count of 1.
- i_clear also clears o_hi_ber. It does not affect the FSM.

Lock FSM (per lane; advances only on i_valid):
- UNLOCKED:
  - A valid block increments good_cnt.
  - An invalid block zeroes good_cnt.
  - When good_cnt reaches LOCK_GOOD, move to LOCKED, zeroing win_cnt and err_cnt.
  - o_block_lock rises in the same cycle as the outputs of the LOCK_GOOD-th block.
- LOCKED:
  - Every block increments win_cnt; invalid blocks also increment err_cnt.
  - When err_cnt reaches ERR_THRESH: move to UNLOCKED, set o_hi_ber, zero good_cnt.
  - When win_cnt reaches ERR_WINDOW without the threshold: zero win_cnt and err_cnt, stay LOCKED.
  - If the threshold error coincides with the window end, loss of lock wins.

Lanes are fully independent; simultaneous strobes on all lanes are required to work.

Test Plan:
- Reset, then 64 all-data blocks (bit0 = 1, payload 0xAA..) on lane 0 -> outputs show {0xAAAAAAAAAAAAAAAA, 2'b01} per block, 1-cycle latency; o_block_lock[0] rises on the 64th; o_data_count[0] = 64; other lanes stay all-zero.
- Lane 1 control block, flags 4'b1110, nibble 0xE, idle payload -> block 0 = {0x07.. payload, 0x1E, 2'b10}; o_ctrl_count[1] = 1; o_inv_flag[1] = 0.
- Lane 2, bit0 = 0 with flags 4'b1111, and separately nibble 0x0 -> o_inv_flag = 1, four error blocks output, o_inv_count[2] = 2, good_cnt zeroed (lock delayed).
- Lane 3 locked, then 16 invalid blocks within a 64-block window -> o_block_lock[3] falls after the 16th, o_hi_ber[3] = 1; 15 invalid per window for 3 windows -> stays locked.
- i_clear asserted together with a valid block on all lanes -> every o_block_count = 1, o_hi_ber = 0, lock state unchanged.
- i_rst_n pulsed low mid-stream for a partial cycle -> all outputs 0 immediately (asynchronous); the stream resumes with counting from 0.

Source files
------------

// File: rtl/baser_257b_multilane_checker.sv
// Multi-lane 257b transcoded-stream checker.
// Each lane expands a 257b block into four 66b blocks and flags malformed input.
// It also keeps saturating statistics and runs a block-lock / high-BER state machine.
// Lanes share only the clock, reset and clear.
module baser_257b_multilane_checker #(
    parameter int NUM_LANES   = 4,
    parameter int TC_WIDTH    = 257,
    parameter int FRAME_WIDTH = 66,
    parameter int CNT_WIDTH   = 32,
    parameter int LOCK_GOOD   = 64,
    parameter int ERR_WINDOW  = 64,
    parameter int ERR_THRESH  = 16
) (
    input  logic                                 clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_LANES-1:0]                 i_valid,
    input  logic [NUM_LANES*TC_WIDTH-1:0]        i_rx_xcoded,
    input  logic                                 i_clear,
    output logic [NUM_LANES-1:0]                 o_valid,
    output logic [NUM_LANES*4*FRAME_WIDTH-1:0]   o_rx_coded,
    output logic [NUM_LANES-1:0]                 o_inv_flag,
    output logic [NUM_LANES-1:0]                 o_block_lock,
    output logic [NUM_LANES-1:0]                 o_hi_ber,
    output logic [NUM_LANES*CNT_WIDTH-1:0]       o_block_count,
    output logic [NUM_LANES*CNT_WIDTH-1:0]       o_data_count,
    output logic [NUM_LANES*CNT_WIDTH-1:0]       o_ctrl_count,
    output logic [NUM_LANES*CNT_WIDTH-1:0]       o_inv_count
);

    localparam int GW   = $clog2(LOCK_GOOD + 1);
    localparam int WW   = $clog2(ERR_WINDOW + 1);
    localparam int EW   = $clog2(ERR_THRESH + 1);
    localparam int XE_W = 320;
    localparam int BW   = 4 * FRAME_WIDTH;

    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_THRESH - 1);

    // Substituted for all four blocks whenever the input block is malformed.
    localparam logic [FRAME_WIDTH-1:0] ERR_BLOCK = {{8{7'h1E}}, 8'h1E, 2'b10};

    typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

    // The first control block carries only the low nibble of its type byte.
    // The full byte is rebuilt from that nibble here.
    function automatic logic [7:0] restore_type(input logic [3:0] nib);
        logic [7:0] t;
        t = 8'h00;
        case (nib)
            4'hE: t = 8'h1E;
            4'hD: t = 8'h2D;
            4'h3: t = 8'h33;
            4'hB: t = 8'h4B;
            4'h5: t = 8'h55;
            4'h6: t = 8'h66;
            4'h8: t = 8'h78;
            4'h7: t = 8'h87;
            4'h9: t = 8'h99;
            4'hA: t = 8'hAA;
            4'h4: t = 8'hB4;
            4'hC: t = 8'hCC;
            4'h2: t = 8'hD2;
            4'h1: t = 8'hE1;
            4'hF: t = 8'hFF;
            default: t = 8'h00;
        endcase
        return t;
    endfunction

    function automatic logic type_known(input logic [7:0] t);
        logic ok;
        ok = 1'b0;
        case (t)
            8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
            8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A clear restarts the count from this cycle's increment; otherwise the count sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] cur,
                                                        input logic inc, input logic clr);
        logic [CNT_WIDTH-1:0] n;
        if (clr) begin
            n = {{(CNT_WIDTH-1){1'b0}}, inc};
        end else if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
            n = cur + 1'b1;
        end else begin
            n = cur;
        end
        return n;
    endfunction

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [TC_WIDTH-1:0]    x;
        logic [XE_W-1:0]        xe;
        logic [8:0]             pos;
        logic                   seen_ctrl;
        logic [63:0]            pl;
        logic [BW-1:0]          dec_blocks;
        logic                   dec_inv;
        logic                   inc_data, inc_ctrl, inc_inv;

        logic                   valid_q, valid_d;
        logic [BW-1:0]          coded_q, coded_d;
        logic                   inv_q, inv_d;
        logic [CNT_WIDTH-1:0]   blk_cnt_q, blk_cnt_d;
        logic [CNT_WIDTH-1:0]   data_cnt_q, data_cnt_d;
        logic [CNT_WIDTH-1:0]   ctrl_cnt_q, ctrl_cnt_d;
        logic [CNT_WIDTH-1:0]   inv_cnt_q, inv_cnt_d;
        lock_state_e            state_q, state_d;
        logic [GW-1:0]          good_q, good_d;
        logic [WW-1:0]          win_q, win_d;
        logic [EW-1:0]          err_q, err_d;
        logic                   hi_ber_q, hi_ber_d;

        assign x  = i_rx_xcoded[k*TC_WIDTH +: TC_WIDTH];
        assign xe = {{(XE_W-TC_WIDTH){1'b0}}, x};

        // Walk the payload field block by block; a data or later control block takes 64 bits.
        // The first control block takes 60 bits, so the bit offset of each block depends on the flags.
        always_comb begin
            dec_blocks = '0;
            dec_inv    = 1'b0;
            pos        = 9'd5;
            seen_ctrl  = 1'b0;
            pl         = '0;
            if (x[0]) begin
                for (int j = 0; j < 4; j++) begin
                    dec_blocks[j*FRAME_WIDTH +: FRAME_WIDTH] = {x[64*j+1 +: 64], 2'b01};
                end
            end else begin
                if (x[4:1] == 4'b1111) begin
                    dec_inv = 1'b1;
                end
                for (int j = 0; j < 4; j++) begin
                    if (x[1+j]) begin
                        pl  = xe[pos +: 64];
                        dec_blocks[j*FRAME_WIDTH +: FRAME_WIDTH] = {pl, 2'b01};
                        pos = pos + 9'd64;
                    end else if (!seen_ctrl) begin
                        seen_ctrl = 1'b1;
                        if (xe[pos +: 4] == 4'h0) begin
                            dec_inv = 1'b1;
                        end
                        pl  = {xe[pos + 9'd4 +: 56], restore_type(xe[pos +: 4])};
                        dec_blocks[j*FRAME_WIDTH +: FRAME_WIDTH] = {pl, 2'b10};
                        pos = pos + 9'd60;
                    end else begin
                        pl  = xe[pos +: 64];
                        if (!type_known(pl[7:0])) begin
                            dec_inv = 1'b1;
                        end
                        dec_blocks[j*FRAME_WIDTH +: FRAME_WIDTH] = {pl, 2'b10};
                        pos = pos + 9'd64;
                    end
                end
            end
            if (dec_inv) begin
                dec_blocks = {4{ERR_BLOCK}};
            end
        end

        assign inc_inv  = i_valid[k] & dec_inv;
        assign inc_data = i_valid[k] & x[0];
        assign inc_ctrl = i_valid[k] & ~x[0] & ~dec_inv;

        // Output data holds between strobes. The statistics counters saturate and honour the clear.
        always_comb begin
            valid_d    = i_valid[k];
            coded_d    = i_valid[k] ? dec_blocks : coded_q;
            inv_d      = i_valid[k] ? dec_inv : inv_q;
            blk_cnt_d  = next_count(blk_cnt_q, i_valid[k], i_clear);
            data_cnt_d = next_count(data_cnt_q, inc_data, i_clear);
            ctrl_cnt_d = next_count(ctrl_cnt_q, inc_ctrl, i_clear);
            inv_cnt_d  = next_count(inv_cnt_q, inc_inv, i_clear);
        end

        // Lock state advances only on strobed blocks; a loss in a clear cycle still sets hi_ber.
        always_comb begin
            state_d  = state_q;
            good_d   = good_q;
            win_d    = win_q;
            err_d    = err_q;
            hi_ber_d = i_clear ? 1'b0 : hi_ber_q;
            if (i_valid[k]) begin
                case (state_q)
                    ST_UNLOCKED: begin
                        if (dec_inv) begin
                            good_d = '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            win_d   = '0;
                            err_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (dec_inv && (err_q == ERR_LAST)) begin
                            state_d  = ST_UNLOCKED;
                            hi_ber_d = 1'b1;
                            good_d   = '0;
                            win_d    = '0;
                            err_d    = '0;
                        end else if (win_q == WIN_LAST) begin
                            win_d = '0;
                            err_d = '0;
                        end else begin
                            win_d = win_q + 1'b1;
                            err_d = err_q + {{(EW-1){1'b0}}, dec_inv};
                        end
                    end
                    default: state_d = ST_UNLOCKED;
                endcase
            end
        end

        // All per-lane state, cleared asynchronously so a mid-stream reset drops the in-flight block.
        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                valid_q    <= 1'b0;
                coded_q    <= '0;
                inv_q      <= 1'b0;
                blk_cnt_q  <= '0;
                data_cnt_q <= '0;
                ctrl_cnt_q <= '0;
                inv_cnt_q  <= '0;
                state_q    <= ST_UNLOCKED;
                good_q     <= '0;
                win_q      <= '0;
                err_q      <= '0;
                hi_ber_q   <= 1'b0;
            end else begin
                valid_q    <= valid_d;
                coded_q    <= coded_d;
                inv_q      <= inv_d;
                blk_cnt_q  <= blk_cnt_d;
                data_cnt_q <= data_cnt_d;
                ctrl_cnt_q <= ctrl_cnt_d;
                inv_cnt_q  <= inv_cnt_d;
                state_q    <= state_d;
                good_q     <= good_d;
                win_q      <= win_d;
                err_q      <= err_d;
                hi_ber_q   <= hi_ber_d;
            end
        end

        assign o_valid[k]                              = valid_q;
        assign o_rx_coded[k*BW +: BW]                  = coded_q;
        assign o_inv_flag[k]                           = inv_q;
        assign o_block_lock[k]                         = (state_q == ST_LOCKED);
        assign o_hi_ber[k]                             = hi_ber_q;
        assign o_block_count[k*CNT_WIDTH +: CNT_WIDTH] = blk_cnt_q;
        assign o_data_count[k*CNT_WIDTH +: CNT_WIDTH]  = data_cnt_q;
        assign o_ctrl_count[k*CNT_WIDTH +: CNT_WIDTH]  = ctrl_cnt_q;
        assign o_inv_count[k*CNT_WIDTH +: CNT_WIDTH]   = inv_cnt_q;
    end

endmodule

// File: tb/tb_baser_257b_multilane_checker.sv
// Directed bench for the multi-lane 257b checker with hand-computed expectations.
// A second instance with 3-bit counters exposes saturation.
module tb_baser_257b_multilane_checker;

    localparam int NL = 4;
    localparam int TW = 257;
    localparam int FW = 66;
    localparam int CW = 32;

    localparam logic [63:0] P_AA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] D1   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D3   = 64'h5555_AAAA_5555_AAAA;
    localparam logic [55:0] P56  = 56'h07_0707_0707_0707;
    localparam logic [63:0] C1   = {56'h12_3456_789A_BCDE, 8'h78};
    localparam logic [63:0] C1B  = {56'h12_3456_789A_BCDE, 8'h11};
    localparam logic [65:0] ERRB = {{8{7'h1E}}, 8'h1E, 2'b10};

    logic                   clk = 1'b0;
    logic                   i_rst_n;
    logic [NL-1:0]          i_valid;
    logic [NL*TW-1:0]       i_rx_xcoded;
    logic                   i_clear;
    logic [NL-1:0]          o_valid, o_inv_flag, o_block_lock, o_hi_ber;
    logic [NL*4*FW-1:0]     o_rx_coded;
    logic [NL*CW-1:0]       o_block_count, o_data_count, o_ctrl_count, o_inv_count;
    logic [NL-1:0]          s_valid, s_inv_flag, s_block_lock, s_hi_ber;
    logic [NL*4*FW-1:0]     s_rx_coded;
    logic [NL*3-1:0]        s_block_count, s_data_count, s_ctrl_count, s_inv_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    baser_257b_multilane_checker dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_rx_xcoded(i_rx_xcoded),
        .i_clear(i_clear), .o_valid(o_valid), .o_rx_coded(o_rx_coded),
        .o_inv_flag(o_inv_flag), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber),
        .o_block_count(o_block_count), .o_data_count(o_data_count),
        .o_ctrl_count(o_ctrl_count), .o_inv_count(o_inv_count)
    );

    baser_257b_multilane_checker #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_rx_xcoded(i_rx_xcoded),
        .i_clear(i_clear), .o_valid(s_valid), .o_rx_coded(s_rx_coded),
        .o_inv_flag(s_inv_flag), .o_block_lock(s_block_lock), .o_hi_ber(s_hi_ber),
        .o_block_count(s_block_count), .o_data_count(s_data_count),
        .o_ctrl_count(s_ctrl_count), .o_inv_count(s_inv_count)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(input int k, input logic [TW-1:0] x, input logic v);
        i_rx_xcoded[k*TW +: TW] = x;
        i_valid[k] = v;
    endtask

    function automatic logic [TW-1:0] dataBlk(input logic [63:0] p);
        return {p, p, p, p, 1'b1};
    endfunction

    function automatic logic [FW-1:0] blk(input int k, input int j);
        return o_rx_coded[(k*4+j)*FW +: FW];
    endfunction

    function automatic logic [CW-1:0] cnt(input logic [NL*CW-1:0] v, input int k);
        return v[k*CW +: CW];
    endfunction

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = '0;
        i_rx_xcoded = '0;
        i_clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 128'(o_valid), 128'(4'h0));
        checkOutput("rst_lock", 128'(o_block_lock), 128'(4'h0));
        checkOutput("rst_count", 128'(o_block_count), 128'(0));
        i_rst_n = 1'b1;
        applyStimulus();

        // Lane 0: 64 all-data blocks reach lock on the 64th
        for (int i = 1; i <= 64; i++) begin
            setLane(0, dataBlk(P_AA), 1'b1);
            if (i == 1) checkOutput("lat_before_edge", 128'(o_valid), 128'(4'h0));
            applyStimulus();
            if (i == 1) begin
                checkOutput("lat_valid", 128'(o_valid), 128'(4'b0001));
                checkOutput("data_blk0", 128'(blk(0, 0)), 128'({P_AA, 2'b01}));
                checkOutput("data_blk3", 128'(blk(0, 3)), 128'({P_AA, 2'b01}));
            end
            if (i == 63) checkOutput("lock0_at63", 128'(o_block_lock[0]), 128'(1'b0));
        end
        setLane(0, '0, 1'b0);
        checkOutput("lock0_at64", 128'(o_block_lock[0]), 128'(1'b1));
        checkOutput("data_cnt0", 128'(cnt(o_data_count, 0)), 128'(32'd64));
        checkOutput("blk_cnt0", 128'(cnt(o_block_count, 0)), 128'(32'd64));
        checkOutput("other_cnt", 128'(o_block_count[NL*CW-1:CW]), 128'(0));
        checkOutput("other_coded", 128'(|o_rx_coded[NL*4*FW-1:4*FW]), 128'(1'b0));
        checkOutput("other_lock", 128'(o_block_lock[NL-1:1]), 128'(3'b000));
        checkOutput("sat_blk_cnt", 128'(s_block_count[2:0]), 128'(3'd7));
        checkOutput("sat_data_cnt", 128'(s_data_count[2:0]), 128'(3'd7));

        // Lane 1: first control block with nibble E, then two control blocks, then a bad type
        setLane(1, {D3, D2, D1, P56, 4'hE, 4'b1110, 1'b0}, 1'b1);
        applyStimulus();
        checkOutput("ctl_blk0", 128'(blk(1, 0)), 128'({P56, 8'h1E, 2'b10}));
        checkOutput("ctl_blk1", 128'(blk(1, 1)), 128'({D1, 2'b01}));
        checkOutput("ctl_blk3", 128'(blk(1, 3)), 128'({D3, 2'b01}));
        checkOutput("ctl_inv", 128'(o_inv_flag[1]), 128'(1'b0));
        checkOutput("ctl_cnt1", 128'(cnt(o_ctrl_count, 1)), 128'(32'd1));
        setLane(1, {D3, D2, C1, P56, 4'h8, 4'b1100, 1'b0}, 1'b1);
        applyStimulus();
        checkOutput("ctl2_blk0", 128'(blk(1, 0)), 128'({P56, 8'h78, 2'b10}));
        checkOutput("ctl2_blk1", 128'(blk(1, 1)), 128'({C1, 2'b10}));
        checkOutput("ctl2_blk2", 128'(blk(1, 2)), 128'({D2, 2'b01}));
        checkOutput("ctl2_inv", 128'(o_inv_flag[1]), 128'(1'b0));
        setLane(1, {D3, D2, C1B, P56, 4'h8, 4'b1100, 1'b0}, 1'b1);
        applyStimulus();
        checkOutput("badtype_inv", 128'(o_inv_flag[1]), 128'(1'b1));
        checkOutput("badtype_blk0", 128'(blk(1, 0)), 128'(ERRB));
        checkOutput("badtype_blk2", 128'(blk(1, 2)), 128'(ERRB));
        checkOutput("ctl_cnt1b", 128'(cnt(o_ctrl_count, 1)), 128'(32'd2));
        checkOutput("inv_cnt1", 128'(cnt(o_inv_count, 1)), 128'(32'd1));
        setLane(1, '0, 1'b0);
        applyStimulus();
        checkOutput("idle_valid1", 128'(o_valid[1]), 128'(1'b0));
        checkOutput("idle_hold1", 128'(blk(1, 0)), 128'(ERRB));
        checkOutput("idle_inv_cnt1", 128'(cnt(o_inv_count, 1)), 128'(32'd1));

        // Lane 2: flags all-data with bit0 clear, and a zero nibble, are both invalid
        setLane(2, {D3, D2, D1, P56, 4'h3, 4'b1111, 1'b0}, 1'b1);
        applyStimulus();
        checkOutput("flags_inv", 128'(o_inv_flag[2]), 128'(1'b1));
        checkOutput("flags_blk3", 128'(blk(2, 3)), 128'(ERRB));
        setLane(2, {D3, D2, D1, P56, 4'h0, 4'b1110, 1'b0}, 1'b1);
        applyStimulus();
        checkOutput("nib0_inv", 128'(o_inv_flag[2]), 128'(1'b1));
        checkOutput("nib0_blk0", 128'(blk(2, 0)), 128'(ERRB));
        checkOutput("inv_cnt2", 128'(cnt(o_inv_count, 2)), 128'(32'd2));
        for (int i = 0; i < 127; i++) begin
            if (i == 63) setLane(2, {D3, D2, D1, P56, 4'h0, 4'b1110, 1'b0}, 1'b1);
            else         setLane(2, dataBlk(D1), 1'b1);
            applyStimulus();
        end
        checkOutput("lock2_delayed", 128'(o_block_lock[2]), 128'(1'b0));
        setLane(2, dataBlk(D1), 1'b1);
        applyStimulus();
        setLane(2, '0, 1'b0);
        checkOutput("lock2_after", 128'(o_block_lock[2]), 128'(1'b1));
        checkOutput("blk_cnt2", 128'(cnt(o_block_count, 2)), 128'(32'd130));
        checkOutput("inv_cnt2b", 128'(cnt(o_inv_count, 2)), 128'(32'd3));
        checkOutput("sum2", 128'(cnt(o_data_count, 2) + cnt(o_ctrl_count, 2) + cnt(o_inv_count, 2)),
                    128'(32'd130));

        // Lane 3: lock, then lose it with 16 consecutive invalid blocks
        for (int i = 0; i < 64; i++) begin
            setLane(3, dataBlk(D2), 1'b1);
            applyStimulus();
        end
        checkOutput("lock3", 128'(o_block_lock[3]), 128'(1'b1));
        for (int i = 1; i <= 16; i++) begin
            setLane(3, {D3, D2, D1, P56, 4'h3, 4'b1111, 1'b0}, 1'b1);
            applyStimulus();
            if (i == 15) checkOutput("lock3_at15", 128'(o_block_lock[3]), 128'(1'b1));
        end
        checkOutput("lock3_lost", 128'(o_block_lock[3]), 128'(1'b0));
        checkOutput("hiber3", 128'(o_hi_ber[3]), 128'(1'b1));
        for (int i = 0; i < 64; i++) begin
            setLane(3, dataBlk(D2), 1'b1);
            applyStimulus();
        end
        setLane(3, '0, 1'b0);
        checkOutput("relock3", 128'(o_block_lock[3]), 128'(1'b1));
        i_clear = 1'b1;
        applyStimulus();
        i_clear = 1'b0;
        checkOutput("clr_hiber3", 128'(o_hi_ber[3]), 128'(1'b0));
        checkOutput("clr_cnt3", 128'(cnt(o_block_count, 3)), 128'(32'd0));
        checkOutput("clr_cnt0", 128'(cnt(o_block_count, 0)), 128'(32'd0));
        checkOutput("clr_lock3", 128'(o_block_lock[3]), 128'(1'b1));

        // 15 invalid per window for three windows keeps lock
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 64; b++) begin
                if (b < 15) setLane(3, {D3, D2, D1, P56, 4'h0, 4'b1110, 1'b0}, 1'b1);
                else        setLane(3, dataBlk(D2), 1'b1);
                applyStimulus();
            end
            checkOutput($sformatf("win%0d_lock3", w), 128'(o_block_lock[3]), 128'(1'b1));
        end

        // 16th error on the last block of a window: loss of lock wins
        for (int b = 0; b < 64; b++) begin
            if (b >= 48) setLane(3, {D3, D2, D1, P56, 4'h0, 4'b1110, 1'b0}, 1'b1);
            else         setLane(3, dataBlk(D2), 1'b1);
            applyStimulus();
            if (b == 62) checkOutput("edge_lock3_63", 128'(o_block_lock[3]), 128'(1'b1));
        end
        setLane(3, '0, 1'b0);
        checkOutput("edge_lock3", 128'(o_block_lock[3]), 128'(1'b0));
        checkOutput("edge_hiber3", 128'(o_hi_ber[3]), 128'(1'b1));
        checkOutput("blk_cnt3", 128'(cnt(o_block_count, 3)), 128'(32'd256));
        checkOutput("inv_cnt3", 128'(cnt(o_inv_count, 3)), 128'(32'd61));
        checkOutput("data_cnt3", 128'(cnt(o_data_count, 3)), 128'(32'd195));

        // Clear together with a valid block on every lane
        for (int k = 0; k < NL; k++) setLane(k, dataBlk(P_AA), 1'b1);
        i_clear = 1'b1;
        applyStimulus();
        i_clear = 1'b0;
        i_valid = '0;
        for (int k = 0; k < NL; k++) begin
            checkOutput($sformatf("clrv_cnt%0d", k), 128'(cnt(o_block_count, k)), 128'(32'd1));
        end
        checkOutput("clrv_hiber", 128'(o_hi_ber), 128'(4'h0));
        checkOutput("clrv_lock", 128'(o_block_lock), 128'(4'b0101));
        checkOutput("clrv_inv3", 128'(cnt(o_inv_count, 3)), 128'(32'd0));

        // Asynchronous reset pulse in the middle of a cycle
        setLane(0, dataBlk(D3), 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 128'(o_valid), 128'(4'h0));
        checkOutput("arst_cnt", 128'(o_block_count), 128'(0));
        checkOutput("arst_lock", 128'(o_block_lock), 128'(4'h0));
        checkOutput("arst_coded", 128'(|o_rx_coded), 128'(1'b0));
        #1;
        i_rst_n = 1'b1;
        i_valid = '0;
        applyStimulus();
        checkOutput("post_rst_cnt", 128'(o_block_count), 128'(0));
        setLane(0, dataBlk(D3), 1'b1);
        applyStimulus();
        i_valid = '0;
        checkOutput("resume_cnt0", 128'(cnt(o_block_count, 0)), 128'(32'd1));
        checkOutput("resume_blk0", 128'(blk(0, 0)), 128'({D3, 2'b01}));
        checkOutput("resume_lock", 128'(o_block_lock), 128'(4'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
